// File: rtl/i2c_reg_slave.sv
// Register-mapped I2C target: NUM_REGS byte registers behind an auto-incrementing pointer.
// SDA is open-drain (pulled low or released); SCL is only observed.
module i2c_reg_slave #(
   parameter logic [6:0]  SLAVE_ADDR = 7'h58,
   parameter int unsigned NUM_REGS   = 4,
   localparam int unsigned PW        = $clog2(NUM_REGS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  scl,
   inout  wire                   sda,
   output logic [NUM_REGS*8-1:0] reg_out,
   output logic                  wr_strobe,
   output logic [PW-1:0]         wr_index,
   output logic                  debug_addr_match,
   output logic [3:0]            debug_state
);

   typedef enum logic [3:0] {
      StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
      StWdata, StWdataAck, StRdata, StRdataAck, StWaitStop
   } state_e;

   state_e        state;
   logic [1:0]    scl_sync, sda_sync;
   logic          scl_prev, sda_prev;
   logic          scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
   logic [7:0]    shreg, rd_byte;
   logic [2:0]    bit_cnt;
   logic          byte_done, rw, sda_oe;
   logic [PW-1:0] ptr;
   logic [7:0]    regs [NUM_REGS];

   assign sda         = sda_oe ? 1'b0 : 1'bz;
   assign debug_state = state;

   assign scl_s     = scl_sync[1];
   assign sda_s     = sda_sync[1];
   assign scl_rise  = scl_s & ~scl_prev;
   assign scl_fall  = ~scl_s & scl_prev;
   assign start_det = scl_s & sda_prev & ~sda_s;
   assign stop_det  = scl_s & ~sda_prev & sda_s;

   always_comb begin
      reg_out = '0;
      for (int i = 0; i < NUM_REGS; i++) reg_out[8*i +: 8] = regs[i];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
         scl_prev <= 1'b1;
         sda_prev <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[0], scl};
         sda_sync <= {sda_sync[0], sda};
         scl_prev <= scl_s;
         sda_prev <= sda_s;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= StIdle;
         shreg            <= '0;
         rd_byte          <= '0;
         bit_cnt          <= '0;
         byte_done        <= 1'b0;
         rw               <= 1'b0;
         sda_oe           <= 1'b0;
         ptr              <= '0;
         wr_strobe        <= 1'b0;
         wr_index         <= '0;
         debug_addr_match <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         wr_strobe <= 1'b0;
         if (stop_det) begin
            state            <= StIdle;
            sda_oe           <= 1'b0;
            debug_addr_match <= 1'b0;
         end else if (start_det) begin
            state            <= StAddr;
            bit_cnt          <= '0;
            byte_done        <= 1'b0;
            sda_oe           <= 1'b0;
            debug_addr_match <= 1'b0;
         end else begin
            // Receive path: master-driven bits are shifted in on SCL rise.
            if (scl_rise && (state == StAddr || state == StPtr || state == StWdata)) begin
               shreg   <= {shreg[6:0], sda_s};
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  byte_done <= 1'b1;
                  if (state == StWdata) begin
                     regs[ptr] <= {shreg[6:0], sda_s};
                     wr_strobe <= 1'b1;
                     wr_index  <= ptr;
                  end
               end
            end
            unique case (state)
               StAddr: if (scl_fall && byte_done) begin
                  byte_done <= 1'b0;
                  rw        <= shreg[0];
                  if (shreg[7:1] == SLAVE_ADDR) begin
                     sda_oe           <= 1'b1;
                     debug_addr_match <= 1'b1;
                     state            <= StAddrAck;
                  end else begin
                     state <= StWaitStop;
                  end
               end
               StAddrAck: if (scl_fall) begin
                  if (rw) begin
                     rd_byte <= regs[ptr];
                     sda_oe  <= ~regs[ptr][7];
                     bit_cnt <= 3'd1;
                     state   <= StRdata;
                  end else begin
                     sda_oe  <= 1'b0;
                     bit_cnt <= '0;
                     state   <= StPtr;
                  end
               end
               StPtr: if (scl_fall && byte_done) begin
                  byte_done <= 1'b0;
                  ptr       <= shreg[PW-1:0];
                  sda_oe    <= 1'b1;
                  state     <= StPtrAck;
               end
               StPtrAck: if (scl_fall) begin
                  sda_oe  <= 1'b0;
                  bit_cnt <= '0;
                  state   <= StWdata;
               end
               StWdata: if (scl_fall && byte_done) begin
                  byte_done <= 1'b0;
                  sda_oe    <= 1'b1;
                  state     <= StWdataAck;
               end
               StWdataAck: if (scl_fall) begin
                  sda_oe  <= 1'b0;
                  ptr     <= ptr + 1'b1;
                  bit_cnt <= '0;
                  state   <= StWdata;
               end
               // bit_cnt counts bits already presented; wrap to 0 means all 8 are out.
               StRdata: if (scl_fall) begin
                  if (bit_cnt == 3'd0) begin
                     sda_oe <= 1'b0;
                     state  <= StRdataAck;
                  end else begin
                     rd_byte <= {rd_byte[6:0], 1'b0};
                     sda_oe  <= ~rd_byte[6];
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end
               StRdataAck: begin
                  if (scl_rise) begin
                     ptr <= ptr + 1'b1;
                     if (sda_s) state <= StWaitStop;
                  end else if (scl_fall) begin
                     rd_byte <= regs[ptr];
                     sda_oe  <= ~regs[ptr][7];
                     bit_cnt <= 3'd1;
                     state   <= StRdata;
                  end
               end
               StIdle, StWaitStop: ;
               default: state <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Bench for i2c_reg_slave: bit-banged I2C master plus a transaction-level register model.
module tb_i2c_reg_slave;
   localparam int NR = 4;
   localparam int Q  = 100;  // quarter SCL period, 10 system clocks

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          m_scl = 1'b1;
   logic          m_low = 1'b0;
   wire           sda_bus;
   logic [NR*8-1:0] reg_out;
   logic          wr_strobe;
   logic [1:0]    wr_index;
   logic          addr_match;
   logic [3:0]    dbg_state;

   int n_chk = 0;
   int n_pass = 0;
   byte unsigned exp_regs [NR];
   int exp_ptr = 0;
   byte unsigned tx_data[$], rx_data[$], exp_rx[$];
   int strobe_log[$], exp_strobe[$];
   int slave_low_cnt = 0;
   int match_cnt = 0;

   always #5 clk = ~clk;
   assign sda_bus = m_low ? 1'b0 : 1'bz;
   pullup (sda_bus);

   i2c_reg_slave #(.SLAVE_ADDR(7'h58), .NUM_REGS(NR)) dut (
      .clk(clk), .rst_n(rst_n), .scl(m_scl), .sda(sda_bus), .reg_out(reg_out),
      .wr_strobe(wr_strobe), .wr_index(wr_index), .debug_addr_match(addr_match),
      .debug_state(dbg_state)
   );

   always @(posedge clk) begin
      if (wr_strobe === 1'b1) strobe_log.push_back(int'(wr_index));
      if (sda_bus === 1'b0 && !m_low) slave_low_cnt++;
      if (addr_match === 1'b1) match_cnt++;
   end

   // ---------------- reference model ----------------
   function automatic logic [NR*8-1:0] model_flat();
      logic [NR*8-1:0] f;
      for (int i = 0; i < NR; i++) f[8*i +: 8] = exp_regs[i];
      return f;
   endfunction

   task automatic model_write(input int p);
      exp_ptr = p % NR;
      exp_strobe.delete();
      foreach (tx_data[i]) begin
         exp_regs[exp_ptr] = tx_data[i];
         exp_strobe.push_back(exp_ptr);
         exp_ptr = (exp_ptr + 1) % NR;
      end
   endtask

   task automatic model_read(input bit use_ptr, input int p, input int n);
      if (use_ptr) exp_ptr = p % NR;
      exp_rx.delete();
      for (int i = 0; i < n; i++) begin
         exp_rx.push_back(exp_regs[exp_ptr]);
         exp_ptr = (exp_ptr + 1) % NR;
      end
   endtask

   // ---------------- bus master ----------------
   task automatic bit_w(input logic b);
      m_low = ~b; #(Q); m_scl = 1'b1; #(2*Q); m_scl = 1'b0; #(Q);
   endtask

   task automatic bit_r(output logic b);
      m_low = 1'b0; #(Q); m_scl = 1'b1; #(Q); b = sda_bus; #(Q); m_scl = 1'b0; #(Q);
   endtask

   task automatic i2c_start;
      m_low = 1'b0; #(Q); m_scl = 1'b1; #(Q); m_low = 1'b1; #(Q); m_scl = 1'b0; #(Q);
   endtask

   task automatic i2c_stop;
      m_low = 1'b1; #(Q); m_scl = 1'b1; #(Q); m_low = 1'b0; #(2*Q);
   endtask

   task automatic byte_w(input logic [7:0] d, output logic acked);
      logic a;
      for (int i = 7; i >= 0; i--) bit_w(d[i]);
      bit_r(a);
      acked = (a === 1'b0);
   endtask

   task automatic byte_r(input logic ack, output logic [7:0] d);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         bit_r(b);
         d[i] = b;
      end
      bit_w(~ack);
   endtask

   task automatic bus_write(input logic [7:0] p, output int nacks);
      logic a;
      nacks = 0;
      i2c_start;
      byte_w(8'hB0, a); nacks += int'(!a);
      byte_w(p, a);     nacks += int'(!a);
      foreach (tx_data[i]) begin
         byte_w(tx_data[i], a);
         nacks += int'(!a);
      end
      i2c_stop;
   endtask

   task automatic bus_read(input bit use_ptr, input logic [7:0] p, input int n,
                           output int nacks);
      logic a;
      logic [7:0] d;
      nacks = 0;
      rx_data.delete();
      i2c_start;
      if (use_ptr) begin
         byte_w(8'hB0, a); nacks += int'(!a);
         byte_w(p, a);     nacks += int'(!a);
         i2c_start;
      end
      byte_w(8'hB1, a); nacks += int'(!a);
      for (int i = 0; i < n; i++) begin
         byte_r(i < n - 1, d);
         rx_data.push_back(d);
      end
      i2c_stop;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      n_chk++; if (reg_out !== '0) $display("FAIL reset_reg_out: got %h want 0", reg_out); else n_pass++;
      n_chk++; if (wr_strobe !== 1'b0) $display("FAIL reset_wr_strobe: got %b want 0", wr_strobe); else n_pass++;
      n_chk++; if (wr_index !== 2'd0) $display("FAIL reset_wr_index: got %0d want 0", wr_index); else n_pass++;
      n_chk++; if (addr_match !== 1'b0) $display("FAIL reset_addr_match: got %b want 0", addr_match); else n_pass++;
      n_chk++; if (dbg_state !== 4'd0) $display("FAIL reset_state: got %0d want 0 (IDLE)", dbg_state); else n_pass++;
      n_chk++; if (sda_bus !== 1'b1) $display("FAIL reset_sda: got %b want 1", sda_bus); else n_pass++;
   endtask

   task automatic test_write_burst;
      int nacks;
      int s0;
      s0 = strobe_log.size();
      tx_data = '{8'hAA, 8'h55};
      bus_write(8'h01, nacks);
      model_write(1);
      n_chk++; if (nacks !== 0) $display("FAIL burst_acks: got %0d nacks want 0", nacks); else n_pass++;
      n_chk++; if (reg_out !== model_flat()) $display("FAIL burst_regs: got %h want %h", reg_out, model_flat()); else n_pass++;
      n_chk++; if (reg_out[15:8] !== 8'hAA || reg_out[23:16] !== 8'h55)
         $display("FAIL burst_reg12: got %h want 55AA", reg_out[23:8]); else n_pass++;
      n_chk++; if (reg_out[7:0] !== 8'h00 || reg_out[31:24] !== 8'h00)
         $display("FAIL burst_reg03: got %h/%h want 00/00", reg_out[31:24], reg_out[7:0]); else n_pass++;
      n_chk++; if (strobe_log.size() - s0 !== exp_strobe.size())
         $display("FAIL burst_strobe_cnt: got %0d want %0d", strobe_log.size() - s0, exp_strobe.size());
      else begin
         n_pass++;
         foreach (exp_strobe[i]) begin
            n_chk++; if (strobe_log[s0+i] !== exp_strobe[i])
               $display("FAIL burst_wr_index: got %0d want %0d", strobe_log[s0+i], exp_strobe[i]); else n_pass++;
         end
      end
   endtask

   task automatic test_ptr_wrap;
      int nacks;
      tx_data = '{8'h11, 8'h22};
      bus_write(8'h03, nacks);
      model_write(3);
      n_chk++; if (nacks !== 0) $display("FAIL wrap_acks: got %0d nacks want 0", nacks); else n_pass++;
      n_chk++; if (reg_out !== model_flat()) $display("FAIL wrap_regs: got %h want %h", reg_out, model_flat()); else n_pass++;
      n_chk++; if (reg_out[31:24] !== 8'h11 || reg_out[7:0] !== 8'h22)
         $display("FAIL wrap_reg30: got %h/%h want 11/22", reg_out[31:24], reg_out[7:0]); else n_pass++;
   endtask

   task automatic test_combined_read;
      int nacks;
      int m0;
      m0 = match_cnt;
      bus_read(1'b1, 8'h01, 3, nacks);
      model_read(1'b1, 1, 3);
      n_chk++; if (nacks !== 0) $display("FAIL read_acks: got %0d nacks want 0", nacks); else n_pass++;
      n_chk++; if (rx_data.size() !== 3 || {rx_data[0], rx_data[1], rx_data[2]} !== 24'hAA5511)
         $display("FAIL read_bytes: got %p want AA 55 11", rx_data); else n_pass++;
      foreach (exp_rx[i]) begin
         n_chk++; if (rx_data[i] !== exp_rx[i])
            $display("FAIL read_model: byte %0d got %h want %h", i, rx_data[i], exp_rx[i]); else n_pass++;
      end
      n_chk++; if (match_cnt <= m0) $display("FAIL read_addr_match: got no assertion want some"); else n_pass++;
      n_chk++; if (dbg_state !== 4'd0) $display("FAIL read_end_state: got %0d want 0", dbg_state); else n_pass++;
      n_chk++; if (sda_bus !== 1'b1) $display("FAIL read_sda_released: got %b want 1", sda_bus); else n_pass++;
   endtask

   task automatic test_addr_mismatch;
      logic a1, a2;
      int l0, m0, s0;
      l0 = slave_low_cnt; m0 = match_cnt; s0 = strobe_log.size();
      i2c_start;
      byte_w(8'hAE, a1);
      byte_w(8'h01, a2);
      byte_w(8'h99, a2);
      i2c_stop;
      n_chk++; if (a1 !== 1'b0) $display("FAIL mismatch_ack: got ack want nack"); else n_pass++;
      n_chk++; if (slave_low_cnt !== l0)
         $display("FAIL mismatch_sda: got %0d low cycles want 0", slave_low_cnt - l0); else n_pass++;
      n_chk++; if (match_cnt !== m0)
         $display("FAIL mismatch_addr_match: got %0d cycles want 0", match_cnt - m0); else n_pass++;
      n_chk++; if (reg_out !== model_flat()) $display("FAIL mismatch_regs: got %h want %h", reg_out, model_flat()); else n_pass++;
      n_chk++; if (strobe_log.size() !== s0)
         $display("FAIL mismatch_strobe: got %0d want 0", strobe_log.size() - s0); else n_pass++;
   endtask

   task automatic test_abort;
      logic a1, a2;
      int s0, nacks;
      s0 = strobe_log.size();
      i2c_start;
      byte_w(8'hB0, a1);
      byte_w(8'h02, a2);
      bit_w(1'b1); bit_w(1'b0); bit_w(1'b1); bit_w(1'b1);
      i2c_stop;
      tx_data.delete();
      model_write(2);
      n_chk++; if (!(a1 && a2)) $display("FAIL abort_acks: got %b%b want 11", a1, a2); else n_pass++;
      n_chk++; if (strobe_log.size() !== s0)
         $display("FAIL abort_strobe: got %0d want 0", strobe_log.size() - s0); else n_pass++;
      n_chk++; if (reg_out !== model_flat()) $display("FAIL abort_regs: got %h want %h", reg_out, model_flat()); else n_pass++;
      n_chk++; if (dbg_state !== 4'd0) $display("FAIL abort_state: got %0d want 0", dbg_state); else n_pass++;
      n_chk++; if (sda_bus !== 1'b1) $display("FAIL abort_sda: got %b want 1", sda_bus); else n_pass++;
      tx_data = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
      bus_write(8'h02, nacks);
      model_write(2);
      n_chk++; if (nacks !== 0) $display("FAIL abort_next_acks: got %0d nacks want 0", nacks); else n_pass++;
      n_chk++; if (reg_out !== model_flat()) $display("FAIL abort_next_regs: got %h want %h", reg_out, model_flat()); else n_pass++;
   endtask

   task automatic test_random;
      int nacks, n, p, s0;
      bit use_ptr;
      for (int it = 0; it < 8; it++) begin
         n = $urandom_range(1, 4);
         p = $urandom_range(0, 255);
         if ($urandom_range(0, 1) == 1) begin
            tx_data.delete();
            for (int k = 0; k < n; k++) tx_data.push_back(8'($urandom_range(0, 255)));
            s0 = strobe_log.size();
            bus_write(8'(p), nacks);
            model_write(p);
            n_chk++; if (nacks !== 0) $display("FAIL rnd_wr_acks: got %0d nacks want 0", nacks); else n_pass++;
            n_chk++; if (reg_out !== model_flat()) $display("FAIL rnd_wr_regs: got %h want %h", reg_out, model_flat()); else n_pass++;
            n_chk++; if (strobe_log.size() - s0 !== exp_strobe.size())
               $display("FAIL rnd_wr_strobe_cnt: got %0d want %0d", strobe_log.size() - s0, exp_strobe.size());
            else begin
               n_pass++;
               foreach (exp_strobe[i]) begin
                  n_chk++; if (strobe_log[s0+i] !== exp_strobe[i])
                     $display("FAIL rnd_wr_index: got %0d want %0d", strobe_log[s0+i], exp_strobe[i]); else n_pass++;
               end
            end
         end else begin
            use_ptr = 1'($urandom_range(0, 1));
            bus_read(use_ptr, 8'(p), n, nacks);
            model_read(use_ptr, p, n);
            n_chk++; if (nacks !== 0) $display("FAIL rnd_rd_acks: got %0d nacks want 0", nacks); else n_pass++;
            foreach (exp_rx[i]) begin
               n_chk++; if (rx_data[i] !== exp_rx[i])
                  $display("FAIL rnd_rd_byte: byte %0d got %h want %h", i, rx_data[i], exp_rx[i]); else n_pass++;
            end
         end
      end
   endtask

   task automatic test_reset_mid_read;
      logic a;
      int nacks;
      tx_data = '{8'h3C};
      bus_write(8'h02, nacks);
      model_write(2);
      i2c_start;
      byte_w(8'hB0, a);
      byte_w(8'h02, a);
      i2c_start;
      byte_w(8'hB1, a);
      n_chk++; if (sda_bus !== 1'b0) $display("FAIL midrd_bit7_driven: got %b want 0", sda_bus); else n_pass++;
      rst_n = 1'b0;
      #1;
      n_chk++; if (sda_bus !== 1'b1) $display("FAIL midrd_sda_release: got %b want 1", sda_bus); else n_pass++;
      n_chk++; if (reg_out !== '0) $display("FAIL midrd_regs: got %h want 0", reg_out); else n_pass++;
      n_chk++; if (dbg_state !== 4'd0) $display("FAIL midrd_state: got %0d want 0", dbg_state); else n_pass++;
      n_chk++; if (addr_match !== 1'b0) $display("FAIL midrd_addr_match: got %b want 0", addr_match); else n_pass++;
      #9;
      i2c_stop;
      rst_n = 1'b1;
      #100;
      foreach (exp_regs[i]) exp_regs[i] = 8'h00;
      exp_ptr = 0;
      bus_read(1'b0, 8'h00, 2, nacks);
      model_read(1'b0, 0, 2);
      n_chk++; if (nacks !== 0) $display("FAIL post_reset_acks: got %0d nacks want 0", nacks); else n_pass++;
      foreach (exp_rx[i]) begin
         n_chk++; if (rx_data[i] !== exp_rx[i])
            $display("FAIL post_reset_byte: byte %0d got %h want %h", i, rx_data[i], exp_rx[i]); else n_pass++;
      end
   endtask

   initial begin
      #2;
      foreach (exp_regs[i]) exp_regs[i] = 8'h00;
      #100;
      rst_n = 1'b1;
      #100;
      test_reset;
      test_write_burst;
      test_ptr_wrap;
      test_combined_read;
      test_addr_mismatch;
      test_abort;
      test_random;
      test_reset_mid_read;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
